step_phase_decoder: RTL

Reader for the stepper coil-drive interface. Monitors the four H-bridge control lines (INA, INA2, INB, INB2) that the motor driver produces, decodes the two-phase-on full-step sequence, and tracks direction and signed step position. It also flags skipped phases and shoot-through patterns. It sits beside the motor driver as a closed-loop position and health monitor, and serves as a self-checking companion in driver benches.

---
 rtl/step_phase_decoder.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/step_phase_decoder.sv
// Full-step coil-drive decoder: watches the four H-bridge control lines,
// filters them, and tracks phase, direction, signed position and faults.
module step_phase_decoder #(
  parameter int unsigned POS_W         = 16,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             INA,
  input  logic             INA2,
  input  logic             INB,
  input  logic             INB2,
  input  logic             ZERO,
  input  logic             CLR_FAULT,
  output logic [POS_W-1:0] POS,
  output logic [1:0]       PHASE,
  output logic             DIR,
  output logic             STEP,
  output logic             SKIP,
  output logic             IDLE,
  output logic             FAULT
);

  localparam int unsigned    CntW   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES);

  typedef enum logic [1:0] {StIdle, StTrack, StFault} state_e;

  logic [3:0]      sync1_q, sync2_q;
  logic [3:0]      cand_q, cand_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            accept;

  logic [1:0]      coil_a, coil_b;
  logic            pat_illegal, pat_off;
  logic [1:0]      new_phase, delta;

  state_e          state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [1:0]      phase_q, phase_d;
  logic            dir_q, dir_d;
  logic            step_q, step_d;
  logic            skip_q, skip_d;

  // Two-flop synchronizer on the asynchronous bridge lines.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q <= 4'b0000;
      sync2_q <= 4'b0000;
    end else begin
      sync1_q <= {INA, INA2, INB, INB2};
      sync2_q <= sync1_q;
    end
  end

  // Stability filter: accept a pattern once, when its run length reaches the threshold.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (sync2_q == cand_q) begin
      if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
    end else begin
      cand_d = sync2_q;
      cnt_d  = CntW'(1);
    end
    // A saturated counter on an unchanged pattern must not re-accept.
    accept = (cnt_d == CntMax) && ((cnt_q != CntMax) || (sync2_q != cand_q));
  end

  // Filter state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cand_q <= 4'b0000;
      cnt_q  <= '0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  end

  // Classify the sampled pattern and map legal two-coil patterns to a phase index.
  always_comb begin
    coil_a      = sync2_q[3:2];
    coil_b      = sync2_q[1:0];
    pat_illegal = (coil_a == 2'b11) || (coil_b == 2'b11);
    pat_off     = !pat_illegal && ((coil_a == 2'b00) || (coil_b == 2'b00));
    new_phase   = 2'd0;
    case ({coil_a, coil_b})
      4'b1010: new_phase = 2'd0;
      4'b0110: new_phase = 2'd1;
      4'b0101: new_phase = 2'd2;
      4'b1001: new_phase = 2'd3;
      default: new_phase = 2'd0;
    endcase
    delta = new_phase - phase_q;
  end

  // Tracking FSM next state, position arithmetic and pulse generation.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    phase_d = phase_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    skip_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (pat_illegal) begin
            state_d = StFault;
          end else if (!pat_off) begin
            phase_d = new_phase;
            state_d = StTrack;
          end
        end
      end
      StTrack: begin
        if (accept) begin
          if (pat_illegal) begin
            state_d = StFault;
          end else if (pat_off) begin
            state_d = StIdle;
          end else begin
            phase_d = new_phase;
            case (delta)
              2'd1: begin
                pos_d  = pos_q + POS_W'(1);
                dir_d  = 1'b1;
                step_d = 1'b1;
              end
              2'd3: begin
                pos_d  = pos_q - POS_W'(1);
                dir_d  = 1'b0;
                step_d = 1'b1;
              end
              2'd2:    skip_d = 1'b1;
              default: ;
            endcase
          end
        end
      end
      StFault: begin
        if (CLR_FAULT) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Zeroing overrides any coincident step on the position only.
    if (ZERO) pos_d = '0;
  end

  // Tracking state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      pos_q   <= '0;
      phase_q <= 2'd0;
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      phase_q <= phase_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      skip_q  <= skip_d;
    end
  end

  assign POS   = pos_q;
  assign PHASE = phase_q;
  assign DIR   = dir_q;
  assign STEP  = step_q;
  assign SKIP  = skip_q;
  assign IDLE  = (state_q != StTrack);
  assign FAULT = (state_q == StFault);

endmodule
